// File: rtl/kf_meas_frontend.sv
// Measurement front end: block-averages N = 2^AVG_LOG2 ADC sample pairs and
// issues one filter-step strobe with the averaged U0/Y0, then idles MIN_GAP cycles.
module kf_meas_frontend #(
    parameter int unsigned W        = 16,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned MIN_GAP  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                adc_valid,
    input  logic signed [W-1:0] adc_u,
    input  logic signed [W-1:0] adc_y,
    output logic                adc_ready,
    output logic signed [W-1:0] U0,
    output logic signed [W-1:0] Y0,
    output logic                clk_en,
    output logic [15:0]         step_cnt
);

    localparam int unsigned AW = W + AVG_LOG2;
    localparam int unsigned CW = AVG_LOG2 + 1;
    localparam int unsigned N  = 1 << AVG_LOG2;
    localparam int unsigned GW = 8;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e               state_q;
    logic signed [AW-1:0] u_acc_q;
    logic signed [AW-1:0] y_acc_q;
    logic [CW-1:0]        cnt_q;
    logic [GW-1:0]        gap_q;
    logic signed [W-1:0]  u0_q;
    logic signed [W-1:0]  y0_q;
    logic                 clk_en_q;
    logic [15:0]          step_cnt_q;

    logic                 xfer_c;
    logic signed [AW-1:0] u_sum_c;
    logic signed [AW-1:0] y_sum_c;

    // Ready must already be low in a reset cycle, so it is decoded from state.
    assign adc_ready = (state_q == ACC) && !reset;
    assign xfer_c    = adc_valid && adc_ready;
    assign u_sum_c   = u_acc_q + AW'(adc_u);
    assign y_sum_c   = y_acc_q + AW'(adc_y);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACC;
            u_acc_q    <= '0;
            y_acc_q    <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            u0_q       <= '0;
            y0_q       <= '0;
            clk_en_q   <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            clk_en_q <= 1'b0;
            unique case (state_q)
                ACC: begin
                    if (xfer_c) begin
                        if (cnt_q == CW'(N - 1)) begin
                            // Nth sample is folded straight into the result.
                            u0_q       <= W'(u_sum_c >>> AVG_LOG2);
                            y0_q       <= W'(y_sum_c >>> AVG_LOG2);
                            clk_en_q   <= 1'b1;
                            step_cnt_q <= step_cnt_q + 16'd1;
                            state_q    <= ISSUE;
                        end else begin
                            u_acc_q <= u_sum_c;
                            y_acc_q <= y_sum_c;
                            cnt_q   <= cnt_q + CW'(1);
                        end
                    end
                end
                ISSUE: begin
                    gap_q   <= GW'(MIN_GAP);
                    state_q <= GAP;
                end
                GAP: begin
                    gap_q <= gap_q - GW'(1);
                    if (gap_q == GW'(1)) begin
                        u_acc_q <= '0;
                        y_acc_q <= '0;
                        cnt_q   <= '0;
                        state_q <= ACC;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

    assign U0       = u0_q;
    assign Y0       = y0_q;
    assign clk_en   = clk_en_q;
    assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_kf_meas_frontend.sv
// Directed bench for kf_meas_frontend: default instance (N=4, gap 3) plus a
// second instance with AVG_LOG2=0, MIN_GAP=1.
module tb_kf_meas_frontend;

    logic               clk;
    logic               reset;
    logic               adc_valid;
    logic signed [15:0] adc_u;
    logic signed [15:0] adc_y;
    logic               adc_ready;
    logic signed [15:0] U0;
    logic signed [15:0] Y0;
    logic               clk_en;
    logic [15:0]        step_cnt;

    logic               v1;
    logic signed [15:0] u1;
    logic signed [15:0] y1;
    logic               r1;
    logic signed [15:0] U0_1;
    logic signed [15:0] Y0_1;
    logic               en1;
    logic [15:0]        cnt1;

    int vectors = 0;
    int errors  = 0;

    kf_meas_frontend dut (
        .clk(clk), .reset(reset), .adc_valid(adc_valid), .adc_u(adc_u), .adc_y(adc_y),
        .adc_ready(adc_ready), .U0(U0), .Y0(Y0), .clk_en(clk_en), .step_cnt(step_cnt)
    );

    kf_meas_frontend #(.W(16), .AVG_LOG2(0), .MIN_GAP(1)) dut1 (
        .clk(clk), .reset(reset), .adc_valid(v1), .adc_u(u1), .adc_y(y1),
        .adc_ready(r1), .U0(U0_1), .Y0(Y0_1), .clk_en(en1), .step_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 32 && !adc_ready; k++) cyc();
        vectors++;
        if (adc_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: adc_ready=%b after 32 cycles, need 1", adc_ready);
        end
    endtask

    task automatic xfer(input logic signed [15:0] u, input logic signed [15:0] y);
        adc_valid = 1'b1;
        adc_u     = u;
        adc_y     = y;
        wait_ready();
        cyc();
        adc_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; adc_valid = 1'b1; adc_u = 16'sd55; adc_y = 16'sd77;
        v1 = 1'b1; u1 = 16'sd5; y1 = 16'sd6;
        cyc(); cyc(); cyc();
        vectors += 6;
        if (adc_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b need 0", adc_ready); end
        if (clk_en !== 1'b0)    begin errors++; $display("FAIL rst_clk_en: got %b need 0", clk_en); end
        if (U0 !== 16'sd0)      begin errors++; $display("FAIL rst_U0: got %0d need 0", U0); end
        if (Y0 !== 16'sd0)      begin errors++; $display("FAIL rst_Y0: got %0d need 0", Y0); end
        if (step_cnt !== 16'd0) begin errors++; $display("FAIL rst_step_cnt: got %0d need 0", step_cnt); end
        if (r1 !== 1'b0)        begin errors++; $display("FAIL rst_ready1: got %b need 0", r1); end
        reset = 1'b0; adc_valid = 1'b0; v1 = 1'b0;
        #1;
        vectors += 2;
        if (adc_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b need 1", adc_ready); end
        if (r1 !== 1'b1)        begin errors++; $display("FAIL post_rst_ready1: got %b need 1", r1); end
    endtask

    task automatic test_average();
        xfer(16'sd0, 16'sd100);
        xfer(16'sd0, 16'sd200);
        xfer(16'sd0, 16'sd300);
        vectors++;
        if (clk_en !== 1'b0) begin errors++; $display("FAIL avg_early_strobe: got %b need 0", clk_en); end
        xfer(16'sd0, 16'sd400);
        vectors += 5;
        if (clk_en !== 1'b1)    begin errors++; $display("FAIL avg_clk_en: got %b need 1", clk_en); end
        if (Y0 !== 16'sd250)    begin errors++; $display("FAIL avg_Y0: got %0d need 250", Y0); end
        if (U0 !== 16'sd0)      begin errors++; $display("FAIL avg_U0: got %0d need 0", U0); end
        if (step_cnt !== 16'd1) begin errors++; $display("FAIL avg_step_cnt: got %0d need 1", step_cnt); end
        if (adc_ready !== 1'b0) begin errors++; $display("FAIL avg_issue_ready: got %b need 0", adc_ready); end
        cyc();
        vectors++;
        if (clk_en !== 1'b0) begin errors++; $display("FAIL avg_strobe_width: got %b need 0", clk_en); end
    endtask

    task automatic test_floor_extremes();
        xfer(16'sh7FFF, -16'sd1);
        xfer(16'sh7FFF, -16'sd1);
        xfer(16'sh7FFF, -16'sd1);
        xfer(16'sh7FFF, -16'sd2);
        vectors += 3;
        if (Y0 !== 16'hFFFE)    begin errors++; $display("FAIL floor_Y0: got %h need fffe", Y0); end
        if (U0 !== 16'h7FFF)    begin errors++; $display("FAIL max_U0: got %h need 7fff", U0); end
        if (step_cnt !== 16'd2) begin errors++; $display("FAIL floor_step_cnt: got %0d need 2", step_cnt); end
        for (int i = 0; i < 4; i++) xfer(16'sh8000, 16'sd0);
        vectors += 3;
        if (U0 !== 16'h8000)    begin errors++; $display("FAIL min_U0: got %h need 8000", U0); end
        if (Y0 !== 16'h0000)    begin errors++; $display("FAIL min_Y0: got %h need 0000", Y0); end
        if (step_cnt !== 16'd3) begin errors++; $display("FAIL min_step_cnt: got %0d need 3", step_cnt); end
    endtask

    task automatic test_back_to_back();
        int   nxt;
        int   last;
        int   strobes;
        int   low_run;
        logic was_ready;
        wait_ready();
        nxt = 0; last = -1; strobes = 0; low_run = 0;
        adc_valid = 1'b1; adc_u = 16'sd0; adc_y = 16'(nxt);
        for (int c = 1; c <= 24; c++) begin
            was_ready = adc_ready;
            cyc();
            if (was_ready) begin nxt++; adc_y = 16'(nxt); end
            if (clk_en) begin
                // Consecutive samples 4j..4j+3 average (floor) to 4j+1.
                vectors++;
                if (Y0 !== 16'(4 * strobes + 1)) begin
                    errors++; $display("FAIL b2b_Y0: strobe %0d got %0d need %0d", strobes, Y0, 4 * strobes + 1);
                end
                if (last >= 0) begin
                    vectors++;
                    if (c - last != 8) begin errors++; $display("FAIL b2b_period: got %0d need 8", c - last); end
                end
                last = c;
                strobes++;
            end
            if (!adc_ready) low_run++;
            else begin
                if (low_run != 0) begin
                    vectors++;
                    if (low_run != 4) begin errors++; $display("FAIL b2b_ready_low: got %0d need 4", low_run); end
                end
                low_run = 0;
            end
        end
        adc_valid = 1'b0;
        vectors += 2;
        if (strobes != 3)       begin errors++; $display("FAIL b2b_strobes: got %0d need 3", strobes); end
        if (step_cnt !== 16'd6) begin errors++; $display("FAIL b2b_step_cnt: got %0d need 6", step_cnt); end
    endtask

    task automatic test_sparse();
        logic signed [15:0] ys [4];
        ys = '{16'sd10, 16'sd20, 16'sd30, 16'sd40};
        wait_ready();
        for (int i = 0; i < 4; i++) begin
            adc_valid = 1'b1; adc_y = ys[i]; adc_u = (i == 3) ? -16'sd3 : -16'sd4;
            cyc();
            adc_valid = 1'b0;
            vectors += 2;
            if (clk_en !== (i == 3)) begin errors++; $display("FAIL sparse_strobe: sample %0d got %b", i, clk_en); end
            if (Y0 !== ((i == 3) ? 16'sd25 : 16'sd9)) begin
                errors++; $display("FAIL sparse_Y0: sample %0d got %0d", i, Y0);
            end
            cyc();
            vectors += 2;
            if (clk_en !== 1'b0) begin errors++; $display("FAIL sparse_idle_strobe: sample %0d got %b need 0", i, clk_en); end
            if (Y0 !== ((i == 3) ? 16'sd25 : 16'sd9)) begin
                errors++; $display("FAIL sparse_hold_Y0: sample %0d got %0d", i, Y0);
            end
        end
        vectors += 2;
        if (U0 !== 16'hFFFC)    begin errors++; $display("FAIL sparse_U0: got %0d need -4", U0); end
        if (step_cnt !== 16'd7) begin errors++; $display("FAIL sparse_step_cnt: got %0d need 7", step_cnt); end
    endtask

    task automatic test_reset_mid();
        wait_ready();
        xfer(16'sd1000, 16'sd1000);
        xfer(16'sd1000, 16'sd1000);
        reset = 1'b1;
        #1;
        vectors++;
        if (adc_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b need 0", adc_ready); end
        cyc();
        reset = 1'b0;
        #1;
        vectors += 3;
        if (clk_en !== 1'b0)    begin errors++; $display("FAIL mid_rst_clk_en: got %b need 0", clk_en); end
        if (step_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_step_cnt: got %0d need 0", step_cnt); end
        if (Y0 !== 16'sd0)      begin errors++; $display("FAIL mid_rst_Y0: got %0d need 0", Y0); end
        for (int i = 0; i < 3; i++) begin
            xfer(16'sd8, 16'sd8);
            vectors++;
            if (clk_en !== 1'b0) begin errors++; $display("FAIL mid_rst_early: xfer %0d got %b need 0", i, clk_en); end
        end
        xfer(16'sd8, 16'sd8);
        vectors += 4;
        if (clk_en !== 1'b1)    begin errors++; $display("FAIL mid_rst_strobe: got %b need 1", clk_en); end
        if (Y0 !== 16'sd8)      begin errors++; $display("FAIL mid_rst_Y0_after: got %0d need 8", Y0); end
        if (U0 !== 16'sd8)      begin errors++; $display("FAIL mid_rst_U0_after: got %0d need 8", U0); end
        if (step_cnt !== 16'd1) begin errors++; $display("FAIL mid_rst_cnt_after: got %0d need 1", step_cnt); end
    endtask

    task automatic test_reset_in_issue();
        wait_ready();
        for (int i = 0; i < 4; i++) xfer(16'sd3, 16'sd3);
        vectors++;
        if (clk_en !== 1'b1) begin errors++; $display("FAIL issue_pre: got %b need 1", clk_en); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        vectors += 4;
        if (clk_en !== 1'b0)    begin errors++; $display("FAIL issue_rst_clk_en: got %b need 0", clk_en); end
        if (step_cnt !== 16'd0) begin errors++; $display("FAIL issue_rst_step_cnt: got %0d need 0", step_cnt); end
        if (U0 !== 16'sd0)      begin errors++; $display("FAIL issue_rst_U0: got %0d need 0", U0); end
        if (adc_ready !== 1'b1) begin errors++; $display("FAIL issue_rst_ready: got %b need 1", adc_ready); end
    endtask

    task automatic test_no_decimation();
        logic signed [15:0] smp [4];
        int   idx;
        logic was_ready;
        smp = '{-16'sd7, 16'sd3, 16'sh7FFF, 16'sh8000};
        idx = 0;
        v1 = 1'b1; y1 = smp[0]; u1 = -smp[0];
        for (int c = 0; c < 9; c++) begin
            vectors++;
            if (r1 !== (c % 3 == 0)) begin errors++; $display("FAIL n1_ready: cycle %0d got %b", c, r1); end
            if (c % 3 == 1) begin
                vectors += 3;
                if (en1 !== 1'b1) begin errors++; $display("FAIL n1_strobe: cycle %0d got %b need 1", c, en1); end
                if (Y0_1 !== smp[c / 3]) begin
                    errors++; $display("FAIL n1_Y0: cycle %0d got %0d need %0d", c, Y0_1, smp[c / 3]);
                end
                if (cnt1 !== 16'(c / 3 + 1)) begin
                    errors++; $display("FAIL n1_step_cnt: cycle %0d got %0d need %0d", c, cnt1, c / 3 + 1);
                end
            end else begin
                vectors++;
                if (en1 !== 1'b0) begin errors++; $display("FAIL n1_idle: cycle %0d got %b need 0", c, en1); end
            end
            was_ready = r1;
            cyc();
            if (was_ready && idx < 3) begin idx++; y1 = smp[idx]; u1 = -smp[idx]; end
        end
        v1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; adc_valid = 1'b0; adc_u = '0; adc_y = '0;
        v1 = 1'b0; u1 = '0; y1 = '0;
        test_reset();
        test_average();
        test_floor_extremes();
        test_back_to_back();
        test_sparse();
        test_reset_mid();
        test_reset_in_issue();
        test_no_decimation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/kf_meas_frontend.md
KF_MEAS_FRONTEND -- requirements
Module: kf_meas_frontend

Interface
REQ-001 Parameter W, default 16: width of input samples and U0/Y0 outputs; two's-complement signed.
REQ-002 Parameter AVG_LOG2, default 2: decimation factor N = 2^AVG_LOG2 samples per filter step; legal range 0..4.
REQ-003 Parameter MIN_GAP, default 3: idle cycles after each step pulse before accepting samples again; legal range 1..255.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 reset  in  1: reset is synchronous and active-high.
REQ-006 adc_valid  in  1: an input sample pair is present on adc_u/adc_y.
REQ-007 adc_u  in  W: control-input sample, signed.
REQ-008 adc_y  in  W: measurement sample, signed.
REQ-009 adc_ready  out  1: block accepts a sample this cycle; transfer occurs when adc_valid && adc_ready.
REQ-010 U0  out  W: decimated control input for the filter stage, registered.
REQ-011 Y0  out  W: decimated measurement for the filter stage, registered.
REQ-012 clk_en  out  1: one-cycle filter step strobe, registered; U0/Y0 are valid whenever it is high.
REQ-013 step_cnt  out  16: count of issued strobes, wraps from 65535 to 0.

Function
REQ-014 The FSM SHALL have three states: ACC, ISSUE and GAP.
REQ-015 ACC: adc_ready=1. Each transfer SHALL add adc_u and adc_y to separate signed accumulators of W+AVG_LOG2 bits and increment the sample count.
REQ-016 ACC -> ISSUE SHALL occur on the transfer that brings the count to N; that sample is included in the sums.
REQ-017 ISSUE, lasting exactly one cycle, beginning the cycle after the Nth transfer:
  - clk_en=1 and adc_ready=0.
  - U0/Y0 = their sums arithmetically shifted right by AVG_LOG2 (floor), truncated to W bits.
  - step_cnt incremented.
  - Gap counter loaded with MIN_GAP.
REQ-018 GAP: adc_ready=0 and clk_en=0; the gap counter SHALL decrement each cycle; on the cycle it reads 1, next state = ACC with the accumulators and count cleared.
REQ-019 U0 and Y0 SHALL hold their values between ISSUE cycles.
REQ-020 The accumulator SHALL never overflow, and the floor-shifted result always fits W bits; no saturation logic is required.
REQ-021 adc_valid while adc_ready=0 SHALL have no effect; the source holds the sample (no drop, no flag).
REQ-022 With AVG_LOG2=0, every transfer SHALL produce an ISSUE with U0/Y0 equal to the sample.
REQ-023 Strobe spacing SHALL be at least N+MIN_GAP cycles; with adc_valid held high it SHALL be exactly N+MIN_GAP+1 cycles.

Reset
REQ-024 reset=1 at a clock edge SHALL force: state ACC, accumulators 0, count 0, gap counter 0, U0=0, Y0=0, clk_en=0, step_cnt=0.
REQ-025 adc_ready SHALL be 0 in any cycle where reset=1, and 1 in the first cycle after reset deasserts.
REQ-026 Reset in any state mid-operation SHALL discard partial sums; no strobe is issued for them.
REQ-027 Reset asserted during ISSUE SHALL leave clk_en=0 from the next cycle, and step_cnt=0.

Verification (W=16, AVG_LOG2=2, MIN_GAP=3 unless noted)
REQ-028 Average: adc_y = 100, 200, 300, 400 and adc_u = 0 on back-to-back valid cycles -> one cycle after the 4th transfer, clk_en=1, Y0=250, U0=0, step_cnt=1.
REQ-029 Floor rounding and extremes:
  - adc_y = -1, -1, -1, -2 -> Y0 = -2 (0xFFFE).
  - adc_u = 4x 32767 -> U0 = 32767.
  - adc_u = 4x -32768 -> U0 = -32768.
REQ-030 Backpressure: adc_valid held high continuously -> adc_ready low for exactly 4 cycles (ISSUE + 3 GAP), clk_en period exactly 8 cycles, no sample lost or duplicated.
REQ-031 Sparse input: adc_valid toggling 1/0 -> a strobe only after 4 transfers; U0/Y0 stable between strobes.
REQ-032 Reset mid-accumulation: 2 transfers of 1000, then reset for 1 cycle, then 4 transfers of 8 -> no strobe before the reset; next strobe Y0=8, step_cnt=1.
REQ-033 AVG_LOG2=0, MIN_GAP=1: each transfer -> strobe the next cycle with Y0 = sample; ready pattern 1,0,0 repeating under continuous valid.
